// File: rtl/alu_seq_executor_if.sv
// Purpose : handshake and operand/result bundle between ID/EX and alu_seq_executor.
// Latency : n/a (wires only).
// Backpressure: in_valid_i/in_ready_o on the request side, out_valid_o/out_ready_i on the result side.
// Signals : in_valid_i, alu_operation_i[3:0], a_data_i, b_data_i, out_ready_i (master -> slave);
//           in_ready_o, out_valid_o, result_o, zero_o, illegal_o (slave -> master).
interface alu_seq_executor_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [3:0]            alu_operation_i;
  logic [DATA_WIDTH-1:0] a_data_i;
  logic [DATA_WIDTH-1:0] b_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  zero_o;
  logic                  illegal_o;

  // Producer of operations / consumer of results (pipeline side).
  modport master (
    output in_valid_i, alu_operation_i, a_data_i, b_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, zero_o, illegal_o
  );

  // Execution unit side.
  modport slave (
    input  in_valid_i, alu_operation_i, a_data_i, b_data_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, zero_o, illegal_o
  );
endinterface

// File: rtl/alu_seq_executor.sv
// Purpose : executes LUI/OR/ADD in one cycle and unsigned MUL by iterative shift-add.
// Latency : accept edge N -> out_valid_o after N (single-cycle ops) or N+DATA_WIDTH+1 (MUL).
// Backpressure: accepts only in IDLE; result held in DONE until out_ready_i.
// Ports   : clk, reset (async, active-high), bus (alu_seq_executor_if.slave) carrying
//           the request handshake, op code, operands and the registered result/flags.
module alu_seq_executor #(
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  alu_seq_executor_if.slave  bus
);

  localparam logic [3:0] OP_LUI = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam int         CNT_W  = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_mul_last;

  logic [DATA_WIDTH-1:0] r_mcand;
  logic [DATA_WIDTH-1:0] r_mplier;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_illegal;

  logic [DATA_WIDTH-1:0] w_sc_result;
  logic                  w_sc_illegal;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    w_mul_last      = 1'b0;
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready_o = 1'b1;
        if (bus.in_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = (bus.alu_operation_i == OP_MUL) ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        // All DATA_WIDTH iterations are done when the counter reaches DATA_WIDTH;
        // this extra cycle moves the accumulator into the result register.
        if (r_cnt == CNT_W'(DATA_WIDTH)) begin
          w_mul_last  = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        bus.out_valid_o = 1'b1;
        if (bus.out_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle datapath; illegal codes produce 0 with the illegal flag.
  always_comb begin
    w_sc_result  = '0;
    w_sc_illegal = 1'b0;
    case (bus.alu_operation_i)
      OP_LUI:  w_sc_result = {bus.b_data_i[15:0], {(DATA_WIDTH-16){1'b0}}};
      OP_OR:   w_sc_result = bus.a_data_i | bus.b_data_i;
      OP_ADD:  w_sc_result = bus.a_data_i + bus.b_data_i;
      OP_MUL:  w_sc_result = '0;
      default: w_sc_illegal = 1'b1;
    endcase
  end

  // Multiplier state and registered result/flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      if (bus.alu_operation_i == OP_MUL) begin
        r_mcand  <= bus.a_data_i;
        r_mplier <= bus.b_data_i;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else begin
        r_result  <= w_sc_result;
        r_zero    <= (w_sc_result == '0);
        r_illegal <= w_sc_illegal;
      end
    end else if (r_state == S_BUSY) begin
      if (w_mul_last) begin
        r_result  <= r_acc;
        r_zero    <= (r_acc == '0);
        r_illegal <= 1'b0;
      end else begin
        // Bits shifted out of the multiplicand only affect product bits above
        // DATA_WIDTH, so dropping them yields the low half of A*B.
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.result_o  = r_result;
  assign bus.zero_o    = r_zero;
  assign bus.illegal_o = r_illegal;

endmodule

// File: tb/tb_alu_seq_executor.sv
// Purpose : directed self-checking bench for alu_seq_executor (DATA_WIDTH=32).
// Latency : n/a.
// Backpressure: exercises held results with out_ready_i low and ignored requests.
module tb_alu_seq_executor;

  localparam logic [3:0] OP_LUI = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_BAD = 4'b1001;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  alu_seq_executor_if #(.DATA_WIDTH(32)) bus ();

  alu_seq_executor #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge (caller ensures the unit is IDLE).
  task automatic accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid_i      = 1'b1;
    bus.alu_operation_i = op;
    bus.a_data_i        = a;
    bus.b_data_i        = b;
    tick();
    bus.in_valid_i      = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] res, input logic zero,
                           input logic ill);
    check({tag, "_valid"}, 64'(bus.out_valid_o), 64'd1);
    check({tag, "_result"}, 64'(bus.result_o), 64'(res));
    check({tag, "_zero"}, 64'(bus.zero_o), 64'(zero));
    check({tag, "_illegal"}, 64'(bus.illegal_o), 64'(ill));
  endtask

  task automatic consume(input string tag);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check({tag, "_idle_valid"}, 64'(bus.out_valid_o), 64'd0);
    check({tag, "_idle_ready"}, 64'(bus.in_ready_o), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic ok;
    n_checks            = 0;
    n_fail              = 0;
    reset               = 1'b1;
    bus.in_valid_i      = 1'b0;
    bus.alu_operation_i = 4'b0;
    bus.a_data_i        = '0;
    bus.b_data_i        = '0;
    bus.out_ready_i     = 1'b0;

    // Reset values
    #1;
    check("rst_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_ready", 64'(bus.in_ready_o), 64'd1);
    check("rst_result", 64'(bus.result_o), 64'd0);
    check("rst_zero", 64'(bus.zero_o), 64'd0);
    check("rst_illegal", 64'(bus.illegal_o), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1: ADD overflow into sign bit, consumer ready from the start
    bus.out_ready_i = 1'b1;
    accept(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    check_out("add1", 32'h8000_0000, 1'b0, 1'b0);
    tick();
    bus.out_ready_i = 1'b0;
    check("add1_idle_valid", 64'(bus.out_valid_o), 64'd0);
    check("add1_idle_ready", 64'(bus.in_ready_o), 64'd1);

    // 2: ADD wrap to zero, LUI, OR
    accept(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    check_out("add_wrap", 32'h0, 1'b1, 1'b0);
    consume("add_wrap");
    accept(OP_LUI, 32'h5555_5555, 32'h1234_ABCD);
    check_out("lui", 32'hABCD_0000, 1'b0, 1'b0);
    consume("lui");
    accept(OP_OR, 32'hF0, 32'h0F);
    check_out("or", 32'hFF, 1'b0, 1'b0);
    consume("or");

    // 3: MUL 7*6 with operands changed after accept; 33 cycles of stall
    accept(OP_MUL, 32'd7, 32'd6);
    bus.a_data_i = 32'hDEAD_BEEF;
    bus.b_data_i = 32'h1234_5678;
    ok = (bus.in_ready_o == 1'b0) && (bus.out_valid_o == 1'b0);
    repeat (32) begin
      tick();
      ok = ok && (bus.in_ready_o == 1'b0) && (bus.out_valid_o == 1'b0);
    end
    check("mul_stall", 64'(ok), 64'd1);
    tick();
    check_out("mul42", 32'd42, 1'b0, 1'b0);
    check("mul42_ready", 64'(bus.in_ready_o), 64'd0);
    consume("mul42");

    accept(OP_MUL, 32'h1_0000, 32'h1_0000);
    repeat (33) tick();
    check_out("mul_ovf", 32'h0, 1'b1, 1'b0);
    consume("mul_ovf");

    // 4: illegal op code, then a legal op clears the flag
    accept(OP_BAD, 32'd5, 32'd6);
    check_out("illegal", 32'h0, 1'b1, 1'b1);
    consume("illegal");
    accept(OP_ADD, 32'd2, 32'd3);
    check_out("after_ill", 32'd5, 1'b0, 1'b0);
    consume("after_ill");

    // 5: result held under backpressure; a new request is ignored
    accept(OP_ADD, 32'h100, 32'h23);
    bus.in_valid_i      = 1'b1;
    bus.alu_operation_i = OP_OR;
    bus.a_data_i        = 32'hFFFF_0000;
    bus.b_data_i        = 32'h0000_FFFF;
    ok = 1'b1;
    repeat (5) begin
      tick();
      ok = ok && (bus.out_valid_o == 1'b1) && (bus.result_o == 32'h123) &&
           (bus.in_ready_o == 1'b0);
    end
    check("hold_stable", 64'(ok), 64'd1);
    check_out("hold", 32'h123, 1'b0, 1'b0);
    bus.in_valid_i = 1'b0;
    consume("hold");

    // 6: asynchronous reset in the middle of a MUL
    accept(OP_MUL, 32'd9, 32'd9);
    repeat (10) tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 64'(bus.out_valid_o), 64'd0);
    check("arst_ready", 64'(bus.in_ready_o), 64'd1);
    check("arst_result", 64'(bus.result_o), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    accept(OP_MUL, 32'd3, 32'd5);
    repeat (33) tick();
    check_out("mul15", 32'd15, 1'b0, 1'b0);
    consume("mul15");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
